// File: rtl/psg_tone_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psg_tone_bank_if: sound-bus register write port and stereo sample outputs.
// Rev 1.0
// ---------------------------------------------------------------------------
interface psg_tone_bank_if #(
  parameter int OUT_W = 8
);
  logic             ce;
  logic             wr_en;
  logic [6:0]       wr_addr;
  logic [7:0]       wr_data;
  logic [OUT_W-1:0] out_l;
  logic [OUT_W-1:0] out_r;
  logic             sample_valid;

  modport master (
    output ce, wr_en, wr_addr, wr_data,
    input  out_l, out_r, sample_valid
  );

  modport slave (
    input  ce, wr_en, wr_addr, wr_data,
    output out_l, out_r, sample_valid
  );
endinterface
`default_nettype wire

// File: rtl/psg_tone_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psg_tone_bank: N-channel square/noise generator with a scanned stereo mixer.
// Rev 1.0
// ---------------------------------------------------------------------------
module psg_tone_bank #(
  parameter int CHANNELS = 6,
  parameter int OUT_W    = 8
) (
  input  wire logic      clk_sys,
  input  wire logic      rst_n,
  psg_tone_bank_if.slave bus
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NSLOT = 1 << IDX_W;
  localparam int SUM_W = OUT_W + 1;
  localparam logic [16:0]      c_SEED = 17'h00001;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(CHANNELS - 1);
  localparam logic [OUT_W-1:0] c_FULL = '1;

  function automatic logic [3:0] f_contrib(
    input logic [3:0] v,
    input logic       ten,
    input logic       nen,
    input logic       tone,
    input logic       noise
  );
    logic [3:0] res;
    res = 4'd0;
    case ({ten, nen})
      2'b10:   res = tone  ? v : 4'd0;
      2'b01:   res = noise ? v : 4'd0;
      2'b11:   res = tone  ? (noise ? (v >> 1) : v) : 4'd0;
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  logic [1:0]       r_rate;
  logic             r_snd_en;
  logic             r_gen_rst;
  logic             r_boot;
  logic [16:0]      r_lfsr;
  logic [9:0]       r_ncnt;
  logic [9:0]       w_nrel;
  logic             w_nstep;
  logic             w_tpulse0;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_acc_l;
  logic [OUT_W-1:0] r_acc_r;
  logic [OUT_W-1:0] r_out_l;
  logic [OUT_W-1:0] r_out_r;
  logic             r_valid;
  logic [SUM_W-1:0] w_sum_l;
  logic [SUM_W-1:0] w_sum_r;
  logic [OUT_W-1:0] w_sat_l;
  logic [OUT_W-1:0] w_sat_r;
  logic [3:0]       w_con_l [NSLOT];
  logic [3:0]       w_con_r [NSLOT];

  // Global registers; writable regardless of gen_rst.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_rate    <= 2'd0;
      r_snd_en  <= 1'b0;
      r_gen_rst <= 1'b0;
    end else if (bus.wr_en) begin
      if (bus.wr_addr == 7'h7E) begin
        r_rate <= bus.wr_data[1:0];
      end
      if (bus.wr_addr == 7'h7F) begin
        r_snd_en  <= bus.wr_data[0];
        r_gen_rst <= bus.wr_data[1];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_boot <= 1'b1;
    end else begin
      r_boot <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_ch
    if (gi < CHANNELS) begin : g_act
      logic [7:0]  r_amp;
      logic [7:0]  r_freq;
      logic [2:0]  r_oct;
      logic        r_ten;
      logic        r_nen;
      logic [16:0] r_cnt;
      logic        r_tone;
      logic        w_sel;
      logic [8:0]  w_base;
      logic [3:0]  w_sh;
      logic [16:0] w_per;
      logic [16:0] w_rel;

      assign w_sel = bus.wr_en && (bus.wr_addr[6:2] == 5'(gi));

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          r_amp  <= 8'd0;
          r_freq <= 8'd0;
          r_oct  <= 3'd0;
          r_ten  <= 1'b0;
          r_nen  <= 1'b0;
        end else if (w_sel) begin
          case (bus.wr_addr[1:0])
            2'd0: r_amp  <= bus.wr_data;
            2'd1: r_freq <= bus.wr_data;
            2'd2: begin
              r_oct <= bus.wr_data[2:0];
              r_ten <= bus.wr_data[4];
              r_nen <= bus.wr_data[5];
            end
            default: ;
          endcase
        end
      end

      // Period is sampled only at reload, so freq/octave writes never cut a half-cycle short.
      assign w_base = 9'd511 - {1'b0, r_freq};
      assign w_sh   = 4'd8 - {1'b0, r_oct};
      assign w_per  = {8'd0, w_base} << w_sh;
      assign w_rel  = w_per - 17'd1;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt  <= 17'd0;
          r_tone <= 1'b0;
        end else if (r_boot || r_gen_rst) begin
          r_cnt  <= w_rel;
          r_tone <= 1'b0;
        end else if (bus.ce) begin
          if (r_cnt == 17'd0) begin
            r_cnt  <= w_rel;
            r_tone <= ~r_tone;
          end else begin
            r_cnt <= r_cnt - 17'd1;
          end
        end
      end

      assign w_con_l[gi] = f_contrib(r_amp[3:0], r_ten, r_nen, r_tone, r_lfsr[0]);
      assign w_con_r[gi] = f_contrib(r_amp[7:4], r_ten, r_nen, r_tone, r_lfsr[0]);

      if (gi == 0) begin : g_tp
        assign w_tpulse0 = bus.ce && !r_boot && !r_gen_rst && (r_cnt == 17'd0);
      end
    end else begin : g_pad
      assign w_con_l[gi] = 4'd0;
      assign w_con_r[gi] = 4'd0;
    end
  end

  always_comb begin
    w_nrel = 10'd255;
    case (r_rate)
      2'd1:    w_nrel = 10'd511;
      2'd2:    w_nrel = 10'd1023;
      default: w_nrel = 10'd255;
    endcase
  end

  // Rate 3 slaves the LFSR to channel 0; its own counter keeps running unused.
  assign w_nstep = (r_rate == 2'd3) ? w_tpulse0 : (bus.ce && (r_ncnt == 10'd0));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_ncnt <= 10'd0;
      r_lfsr <= c_SEED;
    end else if (r_gen_rst) begin
      r_ncnt <= w_nrel;
      r_lfsr <= c_SEED;
    end else begin
      if (bus.ce) begin
        r_ncnt <= (r_ncnt == 10'd0) ? w_nrel : (r_ncnt - 10'd1);
      end
      if (w_nstep) begin
        r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
      end
    end
  end

  assign w_sum_l = {1'b0, r_acc_l} + SUM_W'(w_con_l[r_idx]);
  assign w_sum_r = {1'b0, r_acc_r} + SUM_W'(w_con_r[r_idx]);
  assign w_sat_l = w_sum_l[OUT_W] ? c_FULL : w_sum_l[OUT_W-1:0];
  assign w_sat_r = w_sum_r[OUT_W] ? c_FULL : w_sum_r[OUT_W-1:0];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_valid <= 1'b0;
    end else if (r_gen_rst) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_valid <= 1'b0;
    end else if (bus.ce) begin
      if (r_idx == c_LAST) begin
        r_out_l <= r_snd_en ? w_sat_l : '0;
        r_out_r <= r_snd_en ? w_sat_r : '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_idx   <= '0;
        r_valid <= 1'b1;
      end else begin
        r_acc_l <= w_sat_l;
        r_acc_r <= w_sat_r;
        r_idx   <= r_idx + IDX_W'(1);
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_l        = r_out_l;
  assign bus.out_r        = r_out_r;
  assign bus.sample_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/psg_tone_bank.md
# psg_tone_bank

Parametrised N-channel square-wave/noise sound generator, the successor to the fixed six-channel SAA-style generator. It owns its register file, one tone counter per channel, and a shared 17-bit noise LFSR. It also contains a time-multiplexed stereo mixer that scans one channel per `ce` and emits saturated stereo samples. It sits on the sound bus beside the existing PSGs, and its outputs feed the audio mixer.

## Interface
Parameters:
- `CHANNELS`, 6: number of tone channels, 1..16.
- `OUT_W`, 8: width of each output sample, 4..16.

Ports:
- `clk_sys`  in  1  system clock; the block uses this single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ce`  in  1  8 MHz clock enable, one `clk_sys` wide.
- `wr_en`  in  1  register write strobe, one `clk_sys` wide.
- `wr_addr`  in  7  register address.
- `wr_data`  in  8  register write data.
- `out_l`  out  OUT_W  left sample; unsigned.
- `out_r`  out  OUT_W  right sample; unsigned.
- `sample_valid`  out  1  one-cycle pulse when `out_l`/`out_r` update.

## Operation
- Register map. Writes to any address not listed are ignored. For ch < CHANNELS:
  - `ch*4+0`: amplitude. [3:0] = L, [7:4] = R.
  - `ch*4+1`: freq[7:0].
  - `ch*4+2`: [2:0] octave, [4] tone_en, [5] noise_en.
  - `ch*4+3` is not mapped.
- Global registers:
  - `0x7E` noise: [1:0] rate.
  - `0x7F` ctrl: [0] sound_en, [1] gen_rst.
- Tone generator, per channel:
  - Period P = (511 − freq) << (8 − octave). This is 17 bits wide and has a maximum of 130816.
  - The counter reloads with P−1.
  - On each `ce` the counter decrements.
  - When the counter is 0 on a `ce`: reload, toggle `tone[ch]`, and pulse `tpulse[ch]` for one `clk_sys`.
  - freq/octave writes take effect only at the next reload. No mid-period glitch.
- Noise LFSR:
  - 17 bits, seed 17'h00001.
  - Shift right; the new bit [16] is lfsr[0] ^ lfsr[3].
  - noise = lfsr[0].
  - Rate 0/1/2: the LFSR steps every 256/512/1024 `ce`, using its own counter.
  - Rate 3: the LFSR steps on `tpulse[0]`.
- Per-channel contribution per side, with v = the 4-bit amplitude for that side:
  - tone_en=0, noise_en=0: 0.
  - Tone only: tone ? v : 0.
  - Noise only: noise ? v : 0.
  - Both: tone ? (noise ? v>>1 : v) : 0.
- Mixer:
  - A scan index `idx` runs 0..CHANNELS−1 and advances once per `ce`.
  - L and R accumulators, each OUT_W bits, add the contribution of channel `idx` on each `ce`. Contributions are zero-extended.
  - Additions saturate at 2^OUT_W−1 and never wrap.
  - On the `ce` where idx = CHANNELS−1, the outputs are loaded:
    - `out_l`/`out_r` ← the saturated accumulator value including this final channel.
    - Both accumulators clear, idx ← 0, and `sample_valid` pulses.
  - The sample rate is 8 MHz / CHANNELS.
- sound_en=0 forces `out_l`/`out_r` to 0 when they load. The generators keep running.
- gen_rst=1 holds the generators in reset:
  - All tone counters stay at the reload value and tones stay 0.
  - The LFSR holds the seed and the noise counter holds its reload value.
  - idx and the accumulators are held at 0, and `sample_valid` stays 0.
  - Outputs hold their last value.
- gen_rst and register writes are independent. Registers stay writable while gen_rst=1.

## Timing
- `rst_n` low takes effect immediately, without a clock. All of the following clear:
  - All registers, counters, idx, accumulators, `out_l`, `out_r` and `sample_valid` go to 0.
  - tone[] = 0 and the LFSR = seed.
- Tone counters load P−1 on the first `clk_sys` after `rst_n` deasserts.
- Writes:
  - A write in cycle t is visible in the register at t+1.
  - A ctrl write acts from t+1.
- `out_l`/`out_r`/`sample_valid` are registered. They change on the `clk_sys` edge of the final-channel `ce`, and `sample_valid` is high for exactly that one cycle.
- A channel's contribution uses its tone and noise state as they stand in the cycle it is scanned.
- If a tone toggles in the same cycle it is scanned, the mixer uses the pre-toggle value.
- If `tpulse[0]` and a noise rate write coincide, the new rate applies from the next cycle. That pulse still steps the LFSR only if the old rate was 3.
- CHANNELS=1: every `ce` produces a sample.

## Test plan
- Reset: assert `rst_n` with no clock running → all outputs are 0 at once. After release with ctrl=0x01 and all amplitudes 0 → `sample_valid` pulses every 6 `ce`, with out=0.
- Tone period: ch0 freq=255, oct=7, tone_en, amp=0xF5, ctrl=0x01 → tone0 toggles every 512 `ce`. Samples alternate L 0/5 and R 0/15 in runs of about 85 samples.
- Mixed mode: ch0 tone_en+noise_en, amp=0xFF, noise rate 0 → every nonzero sample is 15 or 7. No sample is nonzero while tone0=0.
- Saturation: CHANNELS=16, OUT_W=7, all channels freq=255, oct=7, amp=0xFF, tone_en → tone-high samples = 127, not 112. Tone-low samples = 0.
- Noise rate 3: ch0 P=512 → the LFSR steps exactly once per tone0 toggle. After 3 toggles, lfsr = the third LFSR step from seed (lfsr[16] = 1 after the first step).
- Generator reset mid-sample: write ctrl=0x03 at idx=3 → no `sample_valid` and outputs frozen. Write ctrl=0x01 → the first `sample_valid` comes exactly 6 `ce` later, and tone0 first toggles P `ce` after release.
